// File: rtl/io_bus_initiator.sv
// rtl/io_bus_initiator.sv - CPU-side initiator turning one in/out request into one device bus transaction
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_req_*, o_req_ready  pipeline request (write flag, device id, write data)
//   o_resp_*, i_resp_ready pipeline response (read data, timeout flag)
//   o_busy                transaction in progress (state != IDLE)
//   o_dev_id              device id to bus, held from the cycle after accept
//   o_wr_valid/o_wr_bits/i_wr_ready  write channel into the bus
//   i_rd_valid/i_rd_bits/o_rd_ready  read channel from the bus
module io_bus_initiator #(
  parameter int unsigned TimeoutCycles = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_dev_id,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_timeout,
  output logic        o_busy,
  output logic [31:0] o_dev_id,
  output logic        o_wr_valid,
  output logic [31:0] o_wr_bits,
  input  logic        i_wr_ready,
  input  logic        i_rd_valid,
  input  logic [31:0] i_rd_bits,
  output logic        o_rd_ready
);

  // A disabled timeout still needs a legal (1-bit) timer vector.
  localparam int TW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TimeoutCycles - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q;
  logic          timeout_hit;

  // Last permitted bus cycle; a handshake in this same cycle still wins.
  assign timeout_hit = (TimeoutCycles != 0) && (timer_q == TIMER_LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    o_req_ready  = 1'b0;
    o_wr_valid   = 1'b0;
    o_rd_ready   = 1'b0;
    o_resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          state_d = i_req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        o_wr_valid = 1'b1;
        if (i_wr_ready || timeout_hit) begin
          state_d = RESP;
        end
      end
      READ: begin
        o_rd_ready = 1'b1;
        if (i_rd_valid || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy = (state_q != IDLE);

  // Datapath: latched request, timer and response registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_dev_id       <= 32'd0;
      o_wr_bits      <= 32'd0;
      o_resp_rdata   <= 32'd0;
      o_resp_timeout <= 1'b0;
      timer_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            o_dev_id  <= i_req_dev_id;
            o_wr_bits <= i_req_wdata;
            timer_q   <= '0;
          end
        end
        WRITE: begin
          if (i_wr_ready) begin
            o_resp_rdata   <= 32'd0;
            o_resp_timeout <= 1'b0;
          end else if (timeout_hit) begin
            o_resp_rdata   <= 32'd0;
            o_resp_timeout <= 1'b1;
          end else if (TimeoutCycles != 0) begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end
        READ: begin
          if (i_rd_valid) begin
            o_resp_rdata   <= i_rd_bits;
            o_resp_timeout <= 1'b0;
          end else if (timeout_hit) begin
            o_resp_rdata   <= 32'd0;
            o_resp_timeout <= 1'b1;
          end else if (TimeoutCycles != 0) begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
